// File: rtl/uart_sched_pkg.sv
// Shared types and defaults for the UART TX scheduler.
// State codes follow the gray-like layout of the TX FSM.
package uart_sched_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        ISSUE   = 3'b001,
        WAIT_HI = 3'b011,
        WAIT_LO = 3'b010,
        GAP     = 3'b110
    } state_t;

    localparam bit CH_A = 1'b0;
    localparam bit CH_B = 1'b1;

    localparam int DW_DEF      = 8;
    localparam int BUSY_TO_DEF = 16;
    localparam int TO_W_DEF    = 5;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester and UART TX side signals of the scheduler.
// The scheduler takes the slave modport, the environment the master.
interface uart_tx_scheduler_if
    import uart_sched_pkg::*;
#(
    parameter int DW = DW_DEF
) ();

    logic          a_valid;
    logic [2*DW-1:0] a_data;
    logic          a_ready;
    logic          b_valid;
    logic [DW-1:0] b_data;
    logic          b_ready;
    logic          tx_busy;
    logic [DW-1:0] tx_p_data;
    logic          tx_data_valid;
    logic          sched_busy;
    logic          owner;
    logic          to_err;

    modport slave (
        input  a_valid, a_data, b_valid, b_data, tx_busy,
        output a_ready, b_ready, tx_p_data, tx_data_valid,
        output sched_busy, owner, to_err
    );

    modport master (
        output a_valid, a_data, b_valid, b_data, tx_busy,
        input  a_ready, b_ready, tx_p_data, tx_data_valid,
        input  sched_busy, owner, to_err
    );

endinterface

// File: rtl/uart_tx_scheduler_rr_arb2.sv
// Two-requester round-robin arbiter with a registered priority pointer.
// Bit 0 is channel A, bit 1 is channel B; grants only while enabled.
module rr_arb2
    import uart_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] grant_o
);

    logic prio_q;
    logic prio_d;

    // Grant the sole requester, or the favoured one on contention.
    always_comb begin
        grant_o = 2'b00;
        prio_d  = prio_q;
        if (en_i) begin
            case (req_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = (prio_q == CH_B) ? 2'b10 : 2'b01;
                default: grant_o = 2'b00;
            endcase
        end
        if (grant_o[CH_A]) begin
            prio_d = CH_B;
        end else if (grant_o[CH_B]) begin
            prio_d = CH_A;
        end
    end

    // Priority pointer; favours A out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= CH_A;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART TX between a two-byte channel A and a one-byte
// channel B, issuing one byte at a time and tracking tx_busy.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int BUSY_TO = BUSY_TO_DEF,
    parameter int TO_W    = TO_W_DEF
) (
    input  logic clk,
    input  logic rst,
    uart_tx_scheduler_if.slave bus
);

    state_t          state_q, state_d;
    logic [2*DW-1:0] hold_q, hold_d;
    logic [1:0]      left_q, left_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0] cnt_inc;
    logic            owner_q, owner_d;
    logic            a_ready_q, a_ready_d;
    logic            b_ready_q, b_ready_d;
    logic            txv_q, txv_d;
    logic [DW-1:0]   txd_q, txd_d;
    logic            to_err_q, to_err_d;
    logic            sbusy_q;
    logic [1:0]      grant;
    logic            arb_en;

    assign arb_en  = (state_q == IDLE);
    assign cnt_inc = cnt_q + TO_W'(1);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .en_i    (arb_en),
        .req_i   ({bus.b_valid, bus.a_valid}),
        .grant_o (grant)
    );

    // Next-state and registered-output decode for the byte scheduler.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        left_d    = left_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        a_ready_d = 1'b0;
        b_ready_d = 1'b0;
        txv_d     = 1'b0;
        txd_d     = txd_q;
        to_err_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant[CH_A]) begin
                    a_ready_d = 1'b1;
                    hold_d    = bus.a_data;
                    left_d    = 2'd2;
                    owner_d   = CH_A;
                    txv_d     = 1'b1;
                    txd_d     = bus.a_data[DW-1:0];
                    state_d   = ISSUE;
                end else if (grant[CH_B]) begin
                    b_ready_d = 1'b1;
                    hold_d    = {{DW{1'b0}}, bus.b_data};
                    left_d    = 2'd1;
                    owner_d   = CH_B;
                    txv_d     = 1'b1;
                    txd_d     = bus.b_data;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_LO;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TO_W'(BUSY_TO)) begin
                        to_err_d = 1'b1;
                        left_d   = 2'd0;
                        state_d  = IDLE;
                    end
                end
            end
            WAIT_LO: begin
                if (!bus.tx_busy) begin
                    left_d = left_q - 2'd1;
                    hold_d = hold_q >> DW;
                    if (left_q == 2'd1) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                txv_d   = 1'b1;
                txd_d   = hold_q[DW-1:0];
                state_d = ISSUE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            left_q    <= '0;
            cnt_q     <= '0;
            owner_q   <= CH_A;
            a_ready_q <= 1'b0;
            b_ready_q <= 1'b0;
            txv_q     <= 1'b0;
            txd_q     <= '0;
            to_err_q  <= 1'b0;
            sbusy_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            left_q    <= left_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            a_ready_q <= a_ready_d;
            b_ready_q <= b_ready_d;
            txv_q     <= txv_d;
            txd_q     <= txd_d;
            to_err_q  <= to_err_d;
            sbusy_q   <= (state_d != IDLE);
        end
    end

    assign bus.a_ready       = a_ready_q;
    assign bus.b_ready       = b_ready_q;
    assign bus.tx_data_valid = txv_q;
    assign bus.tx_p_data     = txd_q;
    assign bus.to_err        = to_err_q;
    assign bus.sched_busy    = sbusy_q;
    assign bus.owner         = owner_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler with a behavioural UART TX
// that raises busy two cycles after a start pulse for 11 cycles.
module tb_uart_tx_scheduler;

    localparam int DW      = 8;
    localparam int BUSY_TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx_dead = 1'b0;
    int   ph;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_dv   = 0;

    logic [DW-1:0] exp_byte[$];
    logic          exp_grant[$];

    uart_tx_scheduler_if #(.DW(DW)) bus ();

    uart_tx_scheduler #(
        .DW(DW), .BUSY_TO(BUSY_TO), .TO_W(5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural UART TX busy flag.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph          <= 0;
            bus.tx_busy <= 1'b0;
        end else begin
            if (bus.tx_data_valid && !tx_dead) ph <= 1;
            else if (ph > 0 && ph < 20) ph <= ph + 1;
            else ph <= 0;
            bus.tx_busy <= (ph >= 1 && ph <= 11);
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic fail(input string nm);
        n_chk++;
        $display("FAIL %s", nm);
    endtask

    function automatic logic sig(input int w);
        case (w)
            0: return bus.a_ready;
            1: return bus.b_ready;
            2: return bus.tx_busy;
            3: return bus.sched_busy;
            4: return bus.to_err;
            5: return bus.tx_data_valid;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_until(input string nm, input int w,
                              input logic lvl, input int max,
                              output int n);
        n = 0;
        while (sig(w) !== lvl) begin
            if (n >= max) begin
                fail({nm, " timeout"});
                return;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, " a_ready"}, 32'(bus.a_ready), 0);
        check({nm, " b_ready"}, 32'(bus.b_ready), 0);
        check({nm, " tx_p_data"}, 32'(bus.tx_p_data), 0);
        check({nm, " tx_dv"}, 32'(bus.tx_data_valid), 0);
        check({nm, " sched_busy"}, 32'(bus.sched_busy), 0);
        check({nm, " owner"}, 32'(bus.owner), 0);
        check({nm, " to_err"}, 32'(bus.to_err), 0);
    endtask

    task automatic settle();
        int n;
        wait_until("idle", 3, 1'b0, 400, n);
        wait_until("tx idle", 2, 1'b0, 400, n);
        repeat (3) @(negedge clk);
    endtask

    // Monitor: pops expected bytes and grants as the DUT presents them.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.tx_data_valid) begin
                n_dv++;
                if (exp_byte.size() == 0) fail("unexpected tx byte");
                else check("tx byte", 32'(bus.tx_p_data),
                           32'(exp_byte.pop_front()));
            end
            if (bus.a_ready && bus.b_ready) begin
                fail("both readies");
            end else if (bus.a_ready || bus.b_ready) begin
                if (exp_grant.size() == 0) begin
                    fail("unexpected grant");
                end else begin
                    logic e;
                    e = exp_grant.pop_front();
                    check("grant ch", 32'(bus.b_ready), 32'(e));
                    check("owner", 32'(bus.owner), 32'(e));
                end
            end
        end
    end

    initial begin
        int n;
        int dv0;
        logic held_bad;
        bus.a_valid = 1'b0;
        bus.a_data  = '0;
        bus.b_valid = 1'b0;
        bus.b_data  = '0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check("post-reset sched_busy", 32'(bus.sched_busy), 0);

        // 1: B only
        exp_grant.push_back(1'b1);
        exp_byte.push_back(8'hA5);
        bus.b_data  = 8'hA5;
        bus.b_valid = 1'b1;
        wait_until("t1 b_ready", 1, 1'b1, 20, n);
        bus.b_valid = 1'b0;
        wait_until("t1 busy hi", 2, 1'b1, 20, n);
        wait_until("t1 busy lo", 2, 1'b0, 30, n);
        check("t1 sched_busy at fall", 32'(bus.sched_busy), 1);
        @(negedge clk);
        check("t1 sched_busy after fall", 32'(bus.sched_busy), 0);
        settle();
        check("t1 dv count", 32'(n_dv), 1);

        // 2: A only, low byte first
        exp_grant.push_back(1'b0);
        exp_byte.push_back(8'hC3);
        exp_byte.push_back(8'h12);
        bus.a_data  = 16'h12C3;
        bus.a_valid = 1'b1;
        wait_until("t2 a_ready", 0, 1'b1, 20, n);
        bus.a_valid = 1'b0;
        wait_until("t2 busy hi", 2, 1'b1, 20, n);
        wait_until("t2 busy lo", 2, 1'b0, 30, n);
        wait_until("t2 second dv", 5, 1'b1, 10, n);
        check("t2 fall to 2nd dv", 32'(n), 2);
        settle();
        check("t2 dv count", 32'(n_dv), 3);

        // 3: contention after reset, A,B,A
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_grant.push_back(1'b0);
        exp_grant.push_back(1'b1);
        exp_grant.push_back(1'b0);
        exp_byte.push_back(8'h5A);
        exp_byte.push_back(8'h3C);
        exp_byte.push_back(8'h7E);
        exp_byte.push_back(8'h5A);
        exp_byte.push_back(8'h3C);
        bus.a_data  = 16'h3C5A;
        bus.b_data  = 8'h7E;
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
        n = 0;
        for (int c = 0; c < 300 && n < 3; c++) begin
            @(negedge clk);
            if (bus.a_ready || bus.b_ready) n++;
        end
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        check("t3 grants", 32'(n), 3);
        settle();

        // 4: busy never rises, timeout
        tx_dead = 1'b1;
        exp_grant.push_back(1'b1);
        exp_byte.push_back(8'h0F);
        dv0 = n_dv;
        bus.b_data  = 8'h0F;
        bus.b_valid = 1'b1;
        wait_until("t4 b_ready", 1, 1'b1, 20, n);
        bus.b_valid = 1'b0;
        wait_until("t4 to_err", 4, 1'b1, 40, n);
        check("t4 to_err latency", 32'(n), BUSY_TO + 1);
        check("t4 idle at err", 32'(bus.sched_busy), 0);
        @(negedge clk);
        check("t4 to_err pulse", 32'(bus.to_err), 0);
        repeat (20) @(negedge clk);
        check("t4 dv count", 32'(n_dv - dv0), 1);
        tx_dead = 1'b0;

        // 5: reset during WAIT_LO of first byte
        exp_grant.push_back(1'b0);
        exp_byte.push_back(8'hEF);
        bus.a_data  = 16'hBEEF;
        bus.a_valid = 1'b1;
        wait_until("t5 a_ready", 0, 1'b1, 20, n);
        bus.a_valid = 1'b0;
        wait_until("t5 busy hi", 2, 1'b1, 20, n);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("t5 async");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_grant.push_back(1'b1);
        exp_byte.push_back(8'h99);
        bus.b_data  = 8'h99;
        bus.b_valid = 1'b1;
        wait_until("t5 b_ready", 1, 1'b1, 20, n);
        bus.b_valid = 1'b0;
        settle();

        // 6: B request held off during an A frame
        exp_grant.push_back(1'b0);
        exp_byte.push_back(8'h21);
        exp_byte.push_back(8'h43);
        exp_grant.push_back(1'b1);
        exp_byte.push_back(8'h55);
        bus.a_data  = 16'h4321;
        bus.a_valid = 1'b1;
        wait_until("t6 a_ready", 0, 1'b1, 20, n);
        bus.a_valid = 1'b0;
        bus.b_data  = 8'h55;
        bus.b_valid = 1'b1;
        held_bad = 1'b0;
        n = 0;
        while (bus.sched_busy && n < 200) begin
            if (bus.b_ready) held_bad = 1'b1;
            @(negedge clk);
            n++;
        end
        check("t6 b held off", 32'(held_bad), 0);
        check("t6 b_ready at idle", 32'(bus.b_ready), 0);
        @(negedge clk);
        check("t6 b granted next", 32'(bus.b_ready), 1);
        bus.b_valid = 1'b0;
        settle();

        check("left bytes", 32'(exp_byte.size()), 0);
        check("left grants", 32'(exp_grant.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: global time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
